syn_mod3: RTL and testbench



---
 rtl/syn_mod3.sv | 102 ++++++++++
 tb/tb_syn_mod3.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/syn_mod3.sv
// syn_mod3: registered modulo-3 reducer.
// Computes in % 3 for an unsigned WIDTH-bit operand and presents the 2-bit
// residue one clock after the operand is accepted. Because 4^k == 1 (mod 3),
// the residue of the operand equals the residue of the sum of its 2-bit
// digits. Stage A sums the digits in a balanced adder tree. Stage B folds
// that sum down to 2 bits and then maps 3 to 0. No division is involved.
//
// Interface: in_valid qualifies in for capture on the rising clk edge.
// There is no ready; every valid operand is accepted. out_valid is high for
// exactly one cycle per accepted operand, one clock after capture. Between
// results, out holds the last residue.
module syn_mod3 #(
  parameter int WIDTH = 32  // legal range 2..32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic [1:0]       out,
  output logic             out_valid
);

  // Number of 2-bit digits after an odd width is zero-extended to even.
  localparam int NDIG  = (WIDTH + 1) >> 1;
  // Wide enough to hold the worst-case digit sum, 3 * NDIG.
  localparam int ACC_W = $clog2(3 * NDIG + 1);

  // Zero-extend the operand to the full 16-digit tree. Unused upper digits
  // are constant zero, so synthesis prunes their adders.
  logic [31:0] opnd;
  assign opnd = 32'(in);

  // Balanced tree levels: 16 leaves -> 8 -> 4 -> 2 -> 1.
  // No partial sum can exceed 3 * NDIG, so ACC_W bits never overflow.
  logic [15:0][ACC_W-1:0] lvl0;
  logic [7:0][ACC_W-1:0]  lvl1;
  logic [3:0][ACC_W-1:0]  lvl2;
  logic [1:0][ACC_W-1:0]  lvl3;
  logic [ACC_W-1:0]       acc;

  // Stage A, leaves: one 2-bit digit per leaf, widened to accumulator width.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      lvl0[i] = ACC_W'(opnd[2*i +: 2]);
    end
  end

  // Stage A, first adder rank: pairwise digit sums.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
    end
  end

  // Stage A, second adder rank.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    end
  end

  // Stage A, third adder rank.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
    end
  end

  // Stage A, root of the tree: the total digit sum.
  assign acc = lvl3[0] + lvl3[1];

  // Stage B works on a fixed 6-bit view of the accumulator (max 48).
  logic [5:0] acc6;
  logic [3:0] fold1;    // <= 3+3+3 = 9
  logic [2:0] fold2;    // digit sums of 0..9 never exceed 4
  logic [1:0] fold3;    // digit sums of 0..4 never exceed 3
  logic [1:0] residue;

  // Stage B: repeated 2-bit digit folds, then map 3 to 0.
  always_comb begin
    acc6    = 6'(acc);
    fold1   = 4'(acc6[1:0]) + 4'(acc6[3:2]) + 4'(acc6[5:4]);
    fold2   = 3'(fold1[1:0]) + 3'(fold1[3:2]);
    fold3   = {1'b0, fold2[2]} + fold2[1:0];
    residue = (fold3 == 2'd3) ? 2'd0 : fold3;
  end

  // Output register: capture the residue for each valid operand and hold
  // it otherwise. Reset clears both outputs immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= residue;
      end
    end
  end

endmodule

// File: tb/tb_syn_mod3.sv
// tb_syn_mod3: self-checking bench for syn_mod3 at WIDTH = 32, 8 and 5.
// Expected residues come from plain integer % 3 on the driven operand.
module tb_syn_mod3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        v32, v8, v5;
  logic [31:0] x32;
  logic [7:0]  x8;
  logic [4:0]  x5;
  logic [1:0]  o32, o8, o5;
  logic        ov32, ov8, ov5;

  syn_mod3 #(.WIDTH(32)) u_w32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in(x32), .out(o32), .out_valid(ov32)
  );
  syn_mod3 #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in(x8), .out(o8), .out_valid(ov8)
  );
  syn_mod3 #(.WIDTH(5)) u_w5 (
    .clk(clk), .reset(reset), .in_valid(v5), .in(x5), .out(o5), .out_valid(ov5)
  );

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q32[$];
  logic [1:0] exp_q8[$];
  logic [1:0] exp_q5[$];
  logic [1:0] held32, held8, held5;  // last residue each DUT should hold
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Check all outputs for the reset state.
  task automatic check_reset(input string tag);
    check_eq({tag, "_w32_out"}, 32'(o32), 0);
    check_eq({tag, "_w32_vld"}, 32'(ov32), 0);
    check_eq({tag, "_w8_out"},  32'(o8), 0);
    check_eq({tag, "_w8_vld"},  32'(ov8), 0);
    check_eq({tag, "_w5_out"},  32'(o5), 0);
    check_eq({tag, "_w5_vld"},  32'(ov5), 0);
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of stimulus (called #1 after a rising edge), wait for the
  // capturing edge, then check each DUT's result one clock later.
  task automatic cycle(input string tag,
                       input logic a32, input logic [31:0] d32,
                       input logic a8,  input logic [7:0]  d8,
                       input logic a5,  input logic [4:0]  d5);
    v32 = a32; x32 = d32;
    v8  = a8;  x8  = d8;
    v5  = a5;  x5  = d5;
    if (a32) exp_q32.push_back(2'(d32 % 32'd3));
    if (a8)  exp_q8.push_back(2'(d8 % 8'd3));
    if (a5)  exp_q5.push_back(2'(d5 % 5'd3));
    @(posedge clk);
    #1;
    if (a32) held32 = exp_q32.pop_front();
    if (a8)  held8  = exp_q8.pop_front();
    if (a5)  held5  = exp_q5.pop_front();
    check_eq({tag, "_w32_vld"}, 32'(ov32), 32'(a32));
    check_eq({tag, "_w32_out"}, 32'(o32), 32'(held32));
    check_eq({tag, "_w8_vld"},  32'(ov8), 32'(a8));
    check_eq({tag, "_w8_out"},  32'(o8), 32'(held8));
    check_eq({tag, "_w5_vld"},  32'(ov5), 32'(a5));
    check_eq({tag, "_w5_out"},  32'(o5), 32'(held5));
    check_eq({tag, "_w32_not3"}, 32'(o32 == 2'd3), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    v32 = 0; v8 = 0; v5 = 0; x32 = '0; x8 = '0; x5 = '0;
    held32 = 0; held8 = 0; held5 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_init");
    reset = 1'b0;

    // Idle cycle right after release: nothing accepted.
    cycle("idle", 0, 32'd0, 0, 8'd0, 0, 5'd0);

    // WIDTH=32 corners, with WIDTH=5 zero-extension checks alongside.
    cycle("corner", 1, 32'hFFFF_FFFF, 1, 8'd255, 1, 5'd31);
    cycle("corner", 1, 32'h8000_0000, 1, 8'd128, 1, 5'd16);
    cycle("corner", 1, 32'hDEAD_BEEF, 1, 8'd254, 1, 5'd30);
    cycle("corner", 1, 32'h0000_0001, 1, 8'd7,   1, 5'd0);
    cycle("corner", 1, 32'h0000_0000, 1, 8'd0,   1, 5'd1);
    // Direct spot checks against the documented residues.
    check_eq("spot_w32_zero", 32'(o32), 0);
    check_eq("spot_w5_one",   32'(o5), 1);

    // WIDTH=8 exhaustive, back-to-back; other widths ride along.
    for (int i = 0; i < 256; i++) begin
      cycle("exh", 1, 32'(i) * 32'd16843009, 1, 8'(i), 1, 5'(i));
    end

    // Hold: accept 5, drop valid and change operand, then re-accept 9.
    cycle("hold_a", 1, 32'd5, 1, 8'd5, 1, 5'd5);
    check_eq("hold_a_two", 32'(o32), 2);
    cycle("hold_b", 0, 32'd9, 0, 8'd9, 0, 5'd9);
    check_eq("hold_b_two", 32'(o32), 2);
    cycle("hold_c", 1, 32'd9, 1, 8'd9, 1, 5'd9);

    // Mid-cycle asynchronous reset while a valid operand is presented.
    cycle("pre_rst", 1, 32'd5, 1, 8'd7, 1, 5'd2);
    v32 = 1; x32 = 32'd7; v8 = 1; x8 = 8'd7; v5 = 1; x5 = 5'd7;
    #3;
    reset = 1'b1;
    #1;
    check_reset("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset("rst_hold");
    end
    reset = 1'b0;
    held32 = 0; held8 = 0; held5 = 0;
    exp_q32.delete(); exp_q8.delete(); exp_q5.delete();
    cycle("post_rst", 0, 32'd7, 0, 8'd7, 0, 5'd7);

    // Random operands with random in_valid.
    for (int i = 0; i < 10000; i++) begin
      cycle("rand",
            1'($urandom_range(0, 3) != 0), $urandom(),
            1'($urandom_range(0, 1)), 8'($urandom()),
            1'($urandom_range(0, 1)), 5'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
